// File: rtl/regfile_pkg.sv
// Purpose: shared constants and types for the register-file read port.
// Latency: none (declarations and one pure helper function only).
// Backpressure: not applicable; imported by the interface, select and top.
package regfile_pkg;

   localparam int NUM_REGS       = 32;
   localparam int REG_ADDR_WIDTH = 5;

   // Register 0 is hard-wired to zero on the read side.
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

   // Output buffer occupancy.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   function automatic logic is_zero_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
      return addr == ZERO_REG;
   endfunction

endpackage

// File: rtl/regfile_read_port_if.sv
// Purpose: read request / response handshake bundle of the read port.
// Latency: none (wires only).
// Backpressure: ReqReady throttles requests, ReadReady throttles responses.
// Ports: ReadReq/ReadRegister/ReqReady (request side),
//        ReadValid/ReadData/ReadReady (response side).
interface regfile_read_port_if #(
   parameter int WORD_LENGTH = 32
);
   import regfile_pkg::*;

   logic                      ReadReq;
   logic [REG_ADDR_WIDTH-1:0] ReadRegister;
   logic                      ReqReady;
   logic                      ReadValid;
   logic [WORD_LENGTH-1:0]    ReadData;
   logic                      ReadReady;

   // master: the requester/consumer; slave: the read port itself.
   modport master (
      output ReadReq, ReadRegister, ReadReady,
      input  ReqReady, ReadValid, ReadData
   );

   modport slave (
      input  ReadReq, ReadRegister, ReadReady,
      output ReqReady, ReadValid, ReadData
   );

endinterface

// File: rtl/regfile_read_select.sv
// Purpose: pick one register word, force register 0 to zero, apply write-first bypass.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the capture value is used.
// Ports: RegFileData_i (flattened bank), ReadRegister_i, write side
//        (RegWrite_i/WriteRegister_i/WriteData_i), capture_o (value to store).
module regfile_read_select import regfile_pkg::*; #(
   parameter int WORD_LENGTH = 32,
   parameter int NUM_REGS    = 32
) (
   input  logic [NUM_REGS*WORD_LENGTH-1:0] RegFileData_i,
   input  logic [REG_ADDR_WIDTH-1:0]       ReadRegister_i,
   input  logic                            RegWrite_i,
   input  logic [REG_ADDR_WIDTH-1:0]       WriteRegister_i,
   input  logic [WORD_LENGTH-1:0]          WriteData_i,
   output logic [WORD_LENGTH-1:0]          capture_o
);

   logic [WORD_LENGTH-1:0] reg_words [NUM_REGS];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_unpack
      assign reg_words[k] = RegFileData_i[k*WORD_LENGTH +: WORD_LENGTH];
   end

   // Zero register wins over everything, including a (meaningless) write to it.
   // A same-cycle write to the requested register wins over the stale bank value.
   always_comb begin
      capture_o = reg_words[ReadRegister_i];
      if (is_zero_reg(ReadRegister_i)) begin
         capture_o = '0;
      end else if (RegWrite_i && (WriteRegister_i == ReadRegister_i)) begin
         capture_o = WriteData_i;
      end
   end

endmodule

// File: rtl/regfile_read_port.sv
// Purpose: register-file read port with write-first bypass and a 2-entry response buffer.
// Latency: response valid the cycle after acceptance (from EMPTY); one request per cycle sustained.
// Backpressure: ReqReady drops while 2 responses are held; head data holds while ReadReady=0.
// Ports: clk, reset (async, active-low), RegFileData/WriteRegister/RegWrite/WriteData
//        (bank contents and same-cycle write), rd (request/response handshake, slave side).
module regfile_read_port import regfile_pkg::*; #(
   parameter int WORD_LENGTH = 32,
   parameter int NUM_REGS    = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REGS*WORD_LENGTH-1:0] RegFileData,
   input  logic [REG_ADDR_WIDTH-1:0]       WriteRegister,
   input  logic                            RegWrite,
   input  logic [WORD_LENGTH-1:0]          WriteData,
   regfile_read_port_if.slave              rd
);

   occ_e                   occ_q, occ_d;
   logic [WORD_LENGTH-1:0] head_q, head_d;
   logic [WORD_LENGTH-1:0] tail_q, tail_d;
   logic [WORD_LENGTH-1:0] capture;
   logic                   req_ready;
   logic                   rsp_valid;
   logic                   accept;
   logic                   pop;

   regfile_read_select #(
      .WORD_LENGTH (WORD_LENGTH),
      .NUM_REGS    (NUM_REGS)
   ) u_select (
      .RegFileData_i   (RegFileData),
      .ReadRegister_i  (rd.ReadRegister),
      .RegWrite_i      (RegWrite),
      .WriteRegister_i (WriteRegister),
      .WriteData_i     (WriteData),
      .capture_o       (capture)
   );

   // Readiness comes from registered occupancy only, so a pop this cycle
   // never frees a slot for this cycle's request (no ready->valid loop).
   assign req_ready = (occ_q != OCC_FULL);
   assign rsp_valid = (occ_q != OCC_EMPTY);
   assign accept    = rd.ReadReq && req_ready;
   assign pop       = rsp_valid && rd.ReadReady;

   assign rd.ReqReady  = req_ready;
   assign rd.ReadValid = rsp_valid;
   assign rd.ReadData  = head_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q  <= OCC_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case (occ_q)
         OCC_EMPTY: begin
            if (accept) begin
               head_d = capture;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && pop) begin
               // Old head leaves while the new entry takes its place.
               head_d = capture;
            end else if (accept) begin
               tail_d = capture;
               occ_d  = OCC_FULL;
            end else if (pop) begin
               // Clear so ReadData reads zero while nothing is held.
               head_d = '0;
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (pop) begin
               head_d = tail_q;
               tail_d = '0;
               occ_d  = OCC_ONE;
            end
         end
         default: begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
            tail_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;
   import regfile_pkg::*;

   localparam int W = 32;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REGS*W-1:0] RegFileData;
   logic [4:0]            WriteRegister;
   logic                  RegWrite;
   logic [W-1:0]          WriteData;

   regfile_read_port_if #(.WORD_LENGTH(W)) rif ();

   regfile_read_port #(
      .WORD_LENGTH (W),
      .NUM_REGS    (NUM_REGS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .RegFileData   (RegFileData),
      .WriteRegister (WriteRegister),
      .RegWrite      (RegWrite),
      .WriteData     (WriteData),
      .rd            (rif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   chk_t         chk_q[$];   // direct checks, evaluated by the monitor
   logic [W-1:0] sb_q[$];    // expected responses in order
   int           errors = 0;
   int           checks = 0;
   int           occ    = 0; // bench model of buffer occupancy

   task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic set_reg(input int k, input logic [W-1:0] v);
      RegFileData[k*W +: W] = v;
   endtask

   // Inputs for this cycle are already applied; model the edge, then advance.
   task automatic cycle(input logic [W-1:0] exp);
      bit acc;
      bit pp;
      post("req_ready",  32'(rif.ReqReady),  32'(occ < 2));
      post("read_valid", 32'(rif.ReadValid), 32'(occ > 0));
      acc = rif.ReadReq && (occ < 2);
      pp  = rif.ReadReady && (occ > 0);
      if (acc) sb_q.push_back(exp);
      occ = occ + int'(acc) - int'(pp);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit req, input int r, input bit rdy, input logic [W-1:0] exp);
      rif.ReadReq      = req;
      rif.ReadRegister = 5'(r);
      rif.ReadReady    = rdy;
      cycle(exp);
   endtask

   task automatic set_write(input bit we, input int r, input logic [W-1:0] d);
      RegWrite      = we;
      WriteRegister = 5'(r);
      WriteData     = d;
   endtask

   // Monitor: evaluates posted checks, pops responses, checks stall stability.
   initial begin : monitor
      chk_t         c;
      logic [W-1:0] e;
      logic         stall;
      logic [W-1:0] stall_dat;
      stall     = 1'b0;
      stall_dat = '0;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.act !== c.exp) begin
               errors++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, c.act, c.exp);
            end
         end
         if (reset === 1'b1 && rif.ReadValid === 1'b1) begin
            if (stall) begin
               checks++;
               if (rif.ReadData !== stall_dat) begin
                  errors++;
                  $display("FAIL stable_data: got 0x%08h expected 0x%08h", rif.ReadData, stall_dat);
               end
            end
            if (rif.ReadReady) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_response: got 0x%08h expected none", rif.ReadData);
               end else begin
                  e = sb_q.pop_front();
                  if (rif.ReadData !== e) begin
                     errors++;
                     $display("FAIL response: got 0x%08h expected 0x%08h", rif.ReadData, e);
                  end
               end
            end
            stall     = !rif.ReadReady;
            stall_dat = rif.ReadData;
         end else begin
            stall = 1'b0;
         end
      end
   end

   initial begin : stim
      reset            = 1'b0;
      rif.ReadReq      = 1'b0;
      rif.ReadRegister = '0;
      rif.ReadReady    = 1'b0;
      set_write(1'b0, 0, '0);
      for (int k = 0; k < NUM_REGS; k++) set_reg(k, 32'(k));
      set_reg(3, 32'h0000_0033);
      set_reg(0, 32'hFFFF_FFFF);

      // Reset state
      #12;
      post("reset_valid", 32'(rif.ReadValid), 32'h0);
      post("reset_data",  rif.ReadData,       32'h0);
      post("reset_ready", 32'(rif.ReqReady),  32'h1);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Zero register, including a write aimed at register 0
      drive(1, 0, 1, 32'h0000_0000);
      set_write(1'b1, 0, 32'h0000_1234);
      drive(1, 0, 1, 32'h0000_0000);
      set_write(1'b1, 7, 32'h0000_7777);
      drive(1, 6, 1, 32'h0000_0006);     // write to another register: no bypass
      set_write(1'b0, 0, '0);
      drive(0, 0, 1, '0);

      // Bypass in the acceptance cycle
      set_write(1'b1, 5, 32'hDEAD_BEEF);
      drive(1, 5, 1, 32'hDEAD_BEEF);
      set_write(1'b0, 0, '0);
      drive(0, 0, 1, '0);

      // Write one cycle later, while stalled; entry must not change
      drive(1, 5, 0, 32'h0000_0005);
      set_write(1'b1, 5, 32'hDEAD_BEEF);
      set_reg(5, 32'h5555_5555);
      drive(0, 0, 0, '0);
      set_write(1'b0, 0, '0);
      drive(0, 0, 1, '0);
      set_reg(5, 32'h0000_0005);
      drive(0, 0, 1, '0);

      // Back-pressure: third request refused, then in-order drain
      drive(1, 1, 0, 32'h0000_0001);
      drive(1, 2, 0, 32'h0000_0002);
      drive(1, 3, 0, 32'h0000_0033);     // not accepted: buffer full
      drive(0, 0, 0, '0);
      drive(0, 0, 1, '0);
      drive(0, 0, 1, '0);
      drive(0, 0, 1, '0);

      // FULL with pop: same-cycle request still refused
      drive(1, 1, 0, 32'h0000_0001);
      drive(1, 2, 0, 32'h0000_0002);
      drive(1, 7, 1, 32'h0000_0007);     // pop only
      drive(1, 7, 1, 32'h0000_0007);     // ONE: accept + pop
      drive(0, 0, 1, '0);
      drive(0, 0, 1, '0);

      // Reset with two responses held
      drive(1, 4, 0, 32'h0000_0004);
      drive(1, 6, 0, 32'h0000_0006);
      rif.ReadReq = 1'b0;
      reset = 1'b0;
      #1;
      post("midreset_valid", 32'(rif.ReadValid), 32'h0);
      post("midreset_data",  rif.ReadData,       32'h0);
      post("midreset_ready", 32'(rif.ReqReady),  32'h1);
      sb_q.delete();
      occ = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1, 3, 1, 32'h0000_0033);
      drive(0, 0, 1, '0);

      // Streaming 1..31 with ReadReady held high
      for (int k = 1; k < NUM_REGS; k++) begin
         drive(1, k, 1, (k == 3) ? 32'h0000_0033 : 32'(k));
      end
      drive(0, 0, 1, '0);
      drive(0, 0, 1, '0);
      drive(0, 0, 1, '0);

      post("drain", 32'(sb_q.size()), 32'h0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
